// File: rtl/spmc_pwm_deadtime.sv
// Complementary high/low gate-drive stage with programmable dead time per PWM channel.
// Optional fault shutdown is built only when SPMC_PWM_DT_FAULT_EN is defined.
module spmc_pwm_deadtime #(
    parameter logic [9:0] BASE_ADR = 10'h0,
    parameter int         CHANNELS = 2,
    parameter int         DT_WIDTH = 8
) (
    input  logic                clk_peri,
    input  logic                reset,
    input  logic [17:0]         do_peri,
    output logic [17:0]         di_peri,
    input  logic [9:0]          addr_peri,
    input  logic                access_peri,
    input  logic                wr_peri,
    input  logic [CHANNELS-1:0] pwm_in,
    input  logic                fault_n,
    output logic [CHANNELS-1:0] out_hi,
    output logic [CHANNELS-1:0] out_lo
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_LO_ON  = 3'd1,
        ST_DEAD_H = 3'd2,
        ST_HI_ON  = 3'd3,
        ST_DEAD_L = 3'd4
    } state_t;

    logic                sel;
    logic                wr_en;
    logic [1:0]          idx;
    logic                enable_q, enable_d;
    logic [DT_WIDTH-1:0] dt_rise_q, dt_rise_d;
    logic [DT_WIDTH-1:0] dt_fall_q, dt_fall_d;
    logic [CHANNELS-1:0] ch_en_q, ch_en_d;
    logic                fault_flag;
    logic                fault_sync;
    logic                unused_sig;

    assign sel        = access_peri && (addr_peri[9:2] == BASE_ADR[9:2]);
    assign wr_en      = sel && wr_peri;
    assign idx        = addr_peri[1:0];
    assign unused_sig = ^do_peri;

    always_comb begin
        enable_d  = enable_q;
        dt_rise_d = dt_rise_q;
        dt_fall_d = dt_fall_q;
        ch_en_d   = ch_en_q;
        if (wr_en) begin
            case (idx)
                2'd0:    enable_d  = do_peri[0];
                2'd1:    dt_rise_d = do_peri[DT_WIDTH-1:0];
                2'd2:    dt_fall_d = do_peri[DT_WIDTH-1:0];
                default: ch_en_d   = do_peri[CHANNELS-1:0];
            endcase
        end
    end

    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset) begin
            enable_q  <= 1'b0;
            dt_rise_q <= '0;
            dt_fall_q <= '0;
            ch_en_q   <= '0;
        end else begin
            enable_q  <= enable_d;
            dt_rise_q <= dt_rise_d;
            dt_fall_q <= dt_fall_d;
            ch_en_q   <= ch_en_d;
        end
    end

`ifdef SPMC_PWM_DT_FAULT_EN
    logic sync1_q, sync2_q;
    logic fault_flag_q, fault_flag_d;

    // A live synchronized fault always beats a simultaneous software clear.
    always_comb begin
        fault_flag_d = fault_flag_q;
        if (!sync2_q)
            fault_flag_d = 1'b1;
        else if (wr_en && (idx == 2'd0) && do_peri[1])
            fault_flag_d = 1'b0;
    end

    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            fault_flag_q <= 1'b0;
        end else begin
            sync1_q      <= fault_n;
            sync2_q      <= sync1_q;
            fault_flag_q <= fault_flag_d;
        end
    end

    assign fault_flag = fault_flag_q;
    assign fault_sync = sync2_q;
`else
    logic unused_fault;
    assign unused_fault = fault_n;
    assign fault_flag   = 1'b0;
    assign fault_sync   = 1'b0;
`endif

    always_comb begin
        di_peri = '0;
        if (sel && !wr_peri) begin
            case (idx)
                2'd0:    di_peri[2:0] = {fault_sync, fault_flag, enable_q};
                2'd1:    di_peri[DT_WIDTH-1:0] = dt_rise_q;
                2'd2:    di_peri[DT_WIDTH-1:0] = dt_fall_q;
                default: di_peri[CHANNELS-1:0] = ch_en_q;
            endcase
        end
    end

    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [DT_WIDTH-1:0] cnt_q   [CHANNELS];
    logic [DT_WIDTH-1:0] cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] hi_q, hi_d, lo_q, lo_d;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic active;
            assign active = enable_q && ch_en_q[gi] && !fault_flag;

            // A dead state that sees the input return goes straight back, swallowing the glitch.
            always_comb begin
                state_d[gi] = state_q[gi];
                cnt_d[gi]   = cnt_q[gi];
                if (!active) begin
                    state_d[gi] = ST_OFF;
                end else begin
                    case (state_q[gi])
                        ST_OFF: begin
                            state_d[gi] = pwm_in[gi] ? ST_DEAD_H : ST_DEAD_L;
                            cnt_d[gi]   = pwm_in[gi] ? dt_rise_q : dt_fall_q;
                        end
                        ST_LO_ON: if (pwm_in[gi]) begin
                            state_d[gi] = ST_DEAD_H;
                            cnt_d[gi]   = dt_rise_q;
                        end
                        ST_HI_ON: if (!pwm_in[gi]) begin
                            state_d[gi] = ST_DEAD_L;
                            cnt_d[gi]   = dt_fall_q;
                        end
                        ST_DEAD_H: begin
                            if (!pwm_in[gi])           state_d[gi] = ST_LO_ON;
                            else if (cnt_q[gi] == '0)  state_d[gi] = ST_HI_ON;
                            else                       cnt_d[gi]   = cnt_q[gi] - DT_WIDTH'(1);
                        end
                        ST_DEAD_L: begin
                            if (pwm_in[gi])            state_d[gi] = ST_HI_ON;
                            else if (cnt_q[gi] == '0)  state_d[gi] = ST_LO_ON;
                            else                       cnt_d[gi]   = cnt_q[gi] - DT_WIDTH'(1);
                        end
                        default: state_d[gi] = ST_OFF;
                    endcase
                end
                hi_d[gi] = (state_d[gi] == ST_HI_ON);
                lo_d[gi] = (state_d[gi] == ST_LO_ON);
            end

            always_ff @(posedge clk_peri or negedge reset) begin
                if (!reset) begin
                    state_q[gi] <= ST_OFF;
                    cnt_q[gi]   <= '0;
                    hi_q[gi]    <= 1'b0;
                    lo_q[gi]    <= 1'b0;
                end else begin
                    state_q[gi] <= state_d[gi];
                    cnt_q[gi]   <= cnt_d[gi];
                    hi_q[gi]    <= hi_d[gi];
                    lo_q[gi]    <= lo_d[gi];
                end
            end
        end
    endgenerate

    assign out_hi = hi_q;
    assign out_lo = lo_q;

endmodule

// File: tb/tb_spmc_pwm_deadtime.sv
// Bench for spmc_pwm_deadtime: directed phases plus random PWM, checked every cycle
// against a run-length model of the dead-time rules.
module tb_spmc_pwm_deadtime;
    localparam logic [9:0] BASE = 10'h010;
    localparam int CH  = 2;
    localparam int DTW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [17:0]   dout = '0;
    logic [17:0]   din;
    logic [9:0]    addr = BASE;
    logic          access = 1'b0;
    logic          wr = 1'b0;
    logic [CH-1:0] pwm = '0;
    logic          fault_n = 1'b1;
    logic [CH-1:0] out_hi, out_lo;

    int errors = 0;
    int checks = 0;

    // Model state: settled side, length of the current opposing run, latched dead time.
    logic          m_en, m_flag, m_s1, m_s2;
    int            m_dr, m_df;
    logic [CH-1:0] m_chen;
    logic          m_off [CH];
    logic          m_s   [CH];
    int            m_run [CH];
    int            m_d   [CH];
    int            hold  [CH];

    spmc_pwm_deadtime #(.BASE_ADR(BASE), .CHANNELS(CH), .DT_WIDTH(DTW)) dut (
        .clk_peri(clk), .reset(rst_n), .do_peri(dout), .di_peri(din),
        .addr_peri(addr), .access_peri(access), .wr_peri(wr),
        .pwm_in(pwm), .fault_n(fault_n), .out_hi(out_hi), .out_lo(out_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_flag = 0; m_s1 = 1; m_s2 = 1; m_dr = 0; m_df = 0; m_chen = '0;
        for (int i = 0; i < CH; i++) begin
            m_off[i] = 1; m_s[i] = 0; m_run[i] = 0; m_d[i] = 0;
        end
    endtask

    function automatic logic [17:0] exp_ctrl();
        logic [17:0] r;
        r = '0;
        r[0] = m_en;
`ifdef SPMC_PWM_DT_FAULT_EN
        r[1] = m_flag;
        r[2] = m_s2;
`endif
        return r;
    endfunction

    task automatic step();
        logic       wr_hit, act, new_flag;
        logic [1:0] idx;
        @(posedge clk);
        wr_hit = access && wr && (addr[9:2] == BASE[9:2]);
        idx = addr[1:0];
        new_flag = m_flag;
`ifdef SPMC_PWM_DT_FAULT_EN
        if (!m_s2) new_flag = 1'b1;
        else if (wr_hit && idx == 2'd0 && dout[1]) new_flag = 1'b0;
`endif
        for (int i = 0; i < CH; i++) begin
            act = m_en && m_chen[i] && !m_flag;
            if (!act) begin
                m_off[i] = 1; m_run[i] = 0;
            end else begin
                if (m_off[i]) begin
                    m_off[i] = 0; m_s[i] = ~pwm[i]; m_run[i] = 0;
                end
                if (pwm[i] != m_s[i]) begin
                    if (m_run[i] == 0) m_d[i] = pwm[i] ? m_dr : m_df;
                    m_run[i]++;
                    if (m_run[i] >= m_d[i] + 2) begin
                        m_s[i] = pwm[i]; m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        if (wr_hit) begin
            case (idx)
                2'd0:    m_en   = dout[0];
                2'd1:    m_dr   = int'(dout[DTW-1:0]);
                2'd2:    m_df   = int'(dout[DTW-1:0]);
                default: m_chen = dout[CH-1:0];
            endcase
        end
        m_s2 = m_s1; m_s1 = fault_n; m_flag = new_flag;
        #1;
        for (int i = 0; i < CH; i++) begin
            check($sformatf("hi%0d", i), 32'(out_hi[i]), 32'(!m_off[i] && m_s[i] && m_run[i] == 0));
            check($sformatf("lo%0d", i), 32'(out_lo[i]), 32'(!m_off[i] && !m_s[i] && m_run[i] == 0));
        end
        check("overlap", 32'(out_hi & out_lo), 32'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr_reg(input logic [1:0] idx, input logic [17:0] data);
        access = 1; wr = 1; addr = BASE | 10'(idx); dout = data;
        step();
        access = 0; wr = 0; dout = '0;
    endtask

    task automatic rd(input logic [1:0] idx, input logic [17:0] exp, input string tag);
        access = 1; wr = 0; addr = BASE | 10'(idx);
        #1;
        check(tag, 32'(din), 32'(exp));
        access = 0;
        #1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", 32'(out_hi), 32'd0);
        check("rst_lo", 32'(out_lo), 32'd0);
        rst_n = 1;
        rd(0, exp_ctrl(), "rst_ctrl");
        rd(1, 18'd0, "rst_dtr");
        rd(3, 18'd0, "rst_chen");

        // Register readback with all-ones writes
        wr_reg(1, 18'h3FFFF); rd(1, 18'h000FF, "rb_dtr");
        wr_reg(2, 18'h3FFFF); rd(2, 18'h000FF, "rb_dtf");
        wr_reg(3, 18'h3FFFF); rd(3, 18'h00003, "rb_chen");
        wr_reg(0, 18'h3FFFF); rd(0, exp_ctrl(), "rb_ctrl");
        check("rb_ctrl_en", 32'(exp_ctrl() & 18'h1), 32'd1);
        access = 1; wr = 0; addr = BASE + 10'd4; #1;
        check("unsel_addr", 32'(din), 32'd0);
        access = 0; addr = BASE; #1;
        check("unsel_acc", 32'(din), 32'd0);
        wr_reg(0, 18'h0);
        run(2);

        // Basic dead time: rise 5, fall 3, channel 1 inverted
        wr_reg(1, 18'd5); wr_reg(2, 18'd3); wr_reg(3, 18'd3);
        pwm = 2'b10;
        wr_reg(0, 18'd1);
        run(20);
        pwm = 2'b01;
        step(); check("basic_lo_fall", 32'(out_lo[0]), 32'd0);
        run(5); check("basic_hi_wait", 32'(out_hi[0]), 32'd0);
        step(); check("basic_hi_rise", 32'(out_hi[0]), 32'd1);
        run(14);
        pwm = 2'b10;
        step(); check("basic_hi_fall", 32'(out_hi[0]), 32'd0);
        run(3); check("basic_lo_wait", 32'(out_lo[0]), 32'd0);
        step(); check("basic_lo_rise", 32'(out_lo[0]), 32'd1);
        run(16);
        for (int p = 0; p < 2; p++) begin
            pwm = 2'b01; run(20);
            pwm = 2'b10; run(20);
        end

        // Glitch shorter than the rise dead time
        wr_reg(1, 18'd10);
        pwm[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(); check("glitch_no_hi", 32'(out_hi[0]), 32'd0);
        end
        pwm[0] = 1'b0;
        step(); check("glitch_lo_back", 32'(out_lo[0]), 32'd1);
        run(15);

        // Channel mask and zero dead time
        wr_reg(3, 18'd1); wr_reg(1, 18'd0); wr_reg(2, 18'd0);
        run(3);
        for (int t = 0; t < 4; t++) begin
            pwm = ~pwm;
            step(); check("dt0_guard", 32'(out_hi[0] | out_lo[0]), 32'd0);
            step(); check("dt0_on", 32'(out_hi[0] ^ out_lo[0]), 32'd1);
            check("mask_ch1", 32'({out_hi[1], out_lo[1]}), 32'd0);
            run(3);
        end

        // Random PWM with dead-time changes mid-flight
        wr_reg(3, 18'd3);
        for (int i = 0; i < CH; i++) hold[i] = 1;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < CH; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    pwm[i] = ~pwm[i];
                    hold[i] = int'($urandom_range(1, 14));
                end
            end
            if (c % 60 == 59) wr_reg(2'($urandom_range(1, 2)), 18'($urandom_range(0, 7)));
            else step();
        end

        // Clearing enable
        wr_reg(1, 18'd2); wr_reg(2, 18'd2);
        pwm = 2'b01; run(8);
        wr_reg(0, 18'd0);
        step(); check("dis_off", 32'({out_hi, out_lo}), 32'd0);
        rd(0, exp_ctrl(), "dis_ctrl");
        wr_reg(0, 18'd1); run(8);

        // Fault pulse, clear while held low, clear after release
        fault_n = 1'b0; step(); fault_n = 1'b1;
        run(2);
        rd(0, exp_ctrl(), "flt_ctrl_k2");
        step();
`ifdef SPMC_PWM_DT_FAULT_EN
        check("flt_off_k3", 32'({out_hi, out_lo}), 32'd0);
        check("flt_flag", 32'(exp_ctrl() & 18'h2), 32'd2);
`endif
        fault_n = 1'b0; run(3);
        wr_reg(0, 18'd3);
        rd(0, exp_ctrl(), "flt_clr_ignored");
        run(2);
        fault_n = 1'b1; run(3);
        wr_reg(0, 18'd3);
        step();
`ifdef SPMC_PWM_DT_FAULT_EN
        check("flt_reentry_dead", 32'({out_hi, out_lo}), 32'd0);
`endif
        rd(0, exp_ctrl(), "flt_cleared");
        run(6);

        // Asynchronous reset while out_hi is high
        pwm = 2'b11; run(6);
        check("pre_rst_hi", 32'(out_hi[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", 32'({out_hi, out_lo}), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd(0, exp_ctrl(), "post_rst_ctrl");
        run(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
